angular_sort_n: RTL and testbench

ANGULAR_SORT_N -- requirements
Module: angular_sort_n

---
 rtl/angular_sort_n_pkg.sv | 9 +
 rtl/angular_sort_n_cross_sign.sv | 21 ++
 rtl/angular_sort_n.sv | 145 ++++++++++++++
 tb/tb_angular_sort_n.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/angular_sort_n_pkg.sv
// angular_sort_n_pkg: shared FSM encoding and default frame geometry for angular_sort_n.
//   N_DEF   default number of points per frame
//   W_DEF   default unsigned coordinate width
//   state_t controller states
package angular_sort_n_pkg;
   localparam int N_DEF = 6;
   localparam int W_DEF = 8;
   typedef enum logic [1:0] {LOAD, VEC, RANK, OUT} state_t;
endpackage

// File: rtl/angular_sort_n_cross_sign.sv
// cross_sign: sign of the 2-D cross product a x b = ax*by - bx*ay.
//   ax, ay    signed (W+1)-bit vector a
//   bx, by    signed (W+1)-bit vector b
//   negative  1 when a x b < 0, meaning b lies clockwise of a
module cross_sign #(
   parameter int W = 8
) (
   input  logic signed [W:0] ax,
   input  logic signed [W:0] ay,
   input  logic signed [W:0] bx,
   input  logic signed [W:0] by,
   output logic              negative
);
   // Two (W+1)-bit products and their difference always fit in 2W+3 bits.
   localparam int CW = 2 * W + 3;
   logic signed [CW-1:0] c;
   always_comb begin
      c        = CW'(ax) * CW'(by) - CW'(bx) * CW'(ay);
      negative = c[CW-1];
   end
endmodule

// File: rtl/angular_sort_n.sv
// angular_sort_n: collects N points, sorts points 1..N-1 by angle around point 0, streams them out.
//   clk, reset              clock, asynchronous active-high reset
//   give_valid, in_ready    point input handshake (dataX, dataY, mode sampled with point 0)
//   ansX, ansY, ans_idx     current output point and its arrival index
//   out_valid, out_ready    output beat handshake
//   out_last                final beat of a frame
//   rank_err                two non-anchor points shared an angle in this frame
module angular_sort_n
   import angular_sort_n_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = W_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 give_valid,
   output logic                 in_ready,
   input  logic [W-1:0]         dataX,
   input  logic [W-1:0]         dataY,
   input  logic                 mode,
   output logic [W-1:0]         ansX,
   output logic [W-1:0]         ansY,
   output logic [$clog2(N)-1:0] ans_idx,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic                 rank_err
);
   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] LASTI = IW'(N - 1);

   state_t state, state_n;
   logic [W-1:0]        px   [N];
   logic [W-1:0]        py   [N];
   logic signed [W:0]   vx   [N];
   logic signed [W:0]   vy   [N];
   logic [IW-1:0]       slot [N];
   logic [N-1:0]        written;
   logic [IW-1:0]       idx, k, j, cnt, b, sel, rank_w;
   logic                mode_r, err, neg;

   cross_sign #(.W(W)) u_cross (
      .ax(vx[k]), .ay(vy[k]), .bx(vx[j]), .by(vy[j]), .negative(neg)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= LOAD;
      else       state <= state_n;
   end

   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         LOAD: begin
            in_ready = 1'b1;
            if (give_valid && idx == LASTI) state_n = VEC;
         end
         VEC:  state_n = RANK;
         RANK: if (k == LASTI && j == LASTI) state_n = OUT;
         OUT: begin
            out_valid = 1'b1;
            if (out_ready && b == LASTI) state_n = LOAD;
         end
         default: state_n = LOAD;
      endcase
   end

   // Rank counts the vectors strictly clockwise of v[k]; v[k] against itself gives 0.
   // Clockwise beat b reads slot (N-b) mod N, so beat 0 still shows the anchor.
   always_comb begin
      rank_w   = cnt + IW'(neg) + IW'(1);
      sel      = (mode_r && b != '0) ? IW'(N) - b : b;
      ans_idx  = out_valid ? slot[sel] : '0;
      ansX     = out_valid ? px[ans_idx] : '0;
      ansY     = out_valid ? py[ans_idx] : '0;
      out_last = out_valid && b == LASTI;
      rank_err = err;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx     <= '0;
         k       <= '0;
         j       <= '0;
         cnt     <= '0;
         b       <= '0;
         mode_r  <= 1'b0;
         err     <= 1'b0;
         written <= '0;
         for (int i = 0; i < N; i++) begin
            px[i]   <= '0;
            py[i]   <= '0;
            vx[i]   <= '0;
            vy[i]   <= '0;
            slot[i] <= '0;
         end
      end else begin
         case (state)
            LOAD: if (give_valid) begin
               px[idx] <= dataX;
               py[idx] <= dataY;
               if (idx == '0) mode_r <= mode;
               idx <= (idx == LASTI) ? '0 : idx + 1'b1;
            end
            VEC: begin
               for (int i = 0; i < N; i++) begin
                  vx[i] <= $signed({1'b0, px[i]}) - $signed({1'b0, px[0]});
                  vy[i] <= $signed({1'b0, py[i]}) - $signed({1'b0, py[0]});
               end
               k   <= IW'(1);
               j   <= IW'(1);
               cnt <= '0;
            end
            RANK: begin
               if (j == LASTI) begin
                  slot[rank_w]    <= k;
                  written[rank_w] <= 1'b1;
                  if (written[rank_w]) err <= 1'b1;
                  cnt <= '0;
                  j   <= IW'(1);
                  k   <= k + 1'b1;
               end else begin
                  cnt <= cnt + IW'(neg);
                  j   <= j + 1'b1;
               end
            end
            OUT: if (out_ready) begin
               if (b == LASTI) begin
                  b       <= '0;
                  idx     <= '0;
                  cnt     <= '0;
                  err     <= 1'b0;
                  written <= '0;
                  for (int i = 0; i < N; i++) slot[i] <= '0;
               end else begin
                  b <= b + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_angular_sort_n.sv
// tb_angular_sort_n: scoreboard bench for angular_sort_n with directed and random frames.
module tb_angular_sort_n;
   localparam int N = 6;
   localparam int W = 8;
   localparam int LAT = 1 + (N - 1) * (N - 1);

   typedef struct packed {
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [2:0]   idx;
      logic         last;
      logic         err;
   } beat_t;

   logic clk = 1'b0;
   logic reset, give_valid, in_ready, mode, out_valid, out_ready, out_last, rank_err;
   logic [W-1:0] dataX, dataY, ansX, ansY;
   logic [2:0] ans_idx;

   angular_sort_n #(.N(N), .W(W)) dut (
      .clk(clk), .reset(reset), .give_valid(give_valid), .in_ready(in_ready),
      .dataX(dataX), .dataY(dataY), .mode(mode), .ansX(ansX), .ansY(ansY),
      .ans_idx(ans_idx), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .rank_err(rank_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int rdy_mode = 0;
   int ph = 0;
   beat_t exp_q[$];

   int fa_x[N] = '{10, 10, 30, 30, 20, 30};
   int fa_y[N] = '{10, 30, 10, 30, 30, 20};
   int ccw_ids[N] = '{0, 2, 5, 3, 4, 1};
   int cw_ids[N] = '{0, 1, 4, 3, 5, 2};
   int fe_x[N] = '{10, 30, 20, 30, 10, 20};
   int fe_y[N] = '{10, 10, 10, 30, 30, 20};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic push_list(input int xs[N], input int ys[N], input int ids[N], input bit e);
      beat_t t;
      for (int b = 0; b < N; b++) begin
         t.x    = W'(xs[ids[b]]);
         t.y    = W'(ys[ids[b]]);
         t.idx  = 3'(ids[b]);
         t.last = (b == N - 1);
         t.err  = e;
         exp_q.push_back(t);
      end
   endtask

   // Angular order from first principles: a point's rank is one more than the number
   // of other vectors lying strictly clockwise of it; slots keep the last writer.
   task automatic model_push(input int xs[N], input int ys[N], input bit m);
      int vx[N], vy[N], slot[N], ids[N];
      bit used[N];
      bit e = 0;
      for (int i = 0; i < N; i++) begin
         vx[i] = xs[i] - xs[0];
         vy[i] = ys[i] - ys[0];
         slot[i] = 0;
         used[i] = 0;
      end
      for (int k = 1; k < N; k++) begin
         int r = 1;
         for (int j = 1; j < N; j++) if (vx[k] * vy[j] - vx[j] * vy[k] < 0) r++;
         if (used[r]) e = 1;
         used[r] = 1;
         slot[r] = k;
      end
      for (int b = 0; b < N; b++) ids[b] = m ? slot[(N - b) % N] : slot[b];
      push_list(xs, ys, ids, e);
   endtask

   task automatic send_frame(input int xs[N], input int ys[N], input bit m, input bit hold, input int maxgap);
      int w = 0;
      @(negedge clk);
      while (!in_ready && w < 3000) begin
         if (give_valid) begin
            dataX = W'($urandom_range(0, 255));
            dataY = W'($urandom_range(0, 255));
            mode  = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         w++;
      end
      if (!in_ready) chk("in_ready_wait", 0, 1);
      for (int i = 0; i < N; i++) begin
         if (i > 0 && maxgap > 0) begin
            int g = $urandom_range(0, maxgap);
            if (g > 0) begin
               give_valid = 1'b0;
               repeat (g) @(negedge clk);
            end
         end
         give_valid = 1'b1;
         dataX = W'(xs[i]);
         dataY = W'(ys[i]);
         mode  = (i == 0) ? m : 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         if (i == N - 1) acc_cyc = cyc;
         if (i < N - 1) @(negedge clk);
      end
      if (hold) begin
         dataX = W'($urandom_range(0, 255));
         dataY = W'($urandom_range(0, 255));
      end else begin
         give_valid = 1'b0;
      end
   endtask

   task automatic check_idle(input string nm);
      chk({nm, "_out_valid"}, int'(out_valid), 0);
      chk({nm, "_in_ready"}, int'(in_ready), 1);
      chk({nm, "_ans"}, int'({ansX, ansY, ans_idx}), 0);
      chk({nm, "_last_err"}, int'({out_last, rank_err}), 0);
   endtask

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin
               out_ready = (ph % 4 == 0) || (ph % 4 == 3);
               ph++;
            end
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin : monitor
      bit seen = 0;
      bit have_prev = 0;
      bit prev_rdy = 0;
      logic [19:0] prev = '0;
      beat_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            seen = 0;
            have_prev = 0;
         end else if (out_valid) begin
            if (!seen) begin
               seen = 1;
               chk("latency", cyc - acc_cyc, LAT);
            end
            if (have_prev && !prev_rdy) chk("hold_stable", int'({ansX, ansY, ans_idx, out_last}), int'(prev));
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_beat", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("ansX", int'(ansX), int'(e.x));
                  chk("ansY", int'(ansY), int'(e.y));
                  chk("ans_idx", int'(ans_idx), int'(e.idx));
                  chk("out_last", int'(out_last), int'(e.last));
                  chk("rank_err", int'(rank_err), int'(e.err));
               end
               if (out_last) seen = 0;
            end
            prev = {ansX, ansY, ans_idx, out_last};
            prev_rdy = out_ready;
            have_prev = 1;
         end else begin
            have_prev = 0;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got %0d cycles expected completion", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int rx[N], ry[N];
      int w = 0;
      reset = 1'b1;
      give_valid = 1'b0;
      dataX = '0;
      dataY = '0;
      mode = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      reset = 1'b0;

      push_list(fa_x, fa_y, ccw_ids, 0);
      send_frame(fa_x, fa_y, 0, 0, 0);
      push_list(fa_x, fa_y, cw_ids, 0);
      send_frame(fa_x, fa_y, 1, 0, 0);

      @(negedge clk);
      rdy_mode = 1;
      ph = 0;
      push_list(fa_x, fa_y, ccw_ids, 0);
      send_frame(fa_x, fa_y, 0, 0, 0);
      rdy_mode = 0;

      model_push(fe_x, fe_y, 0);
      send_frame(fe_x, fe_y, 0, 0, 0);

      send_frame(fa_x, fa_y, 1, 0, 0);
      repeat (8) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_idle("midrank_reset");
      @(negedge clk);
      reset = 1'b0;
      push_list(fa_x, fa_y, ccw_ids, 0);
      send_frame(fa_x, fa_y, 0, 0, 0);

      push_list(fa_x, fa_y, cw_ids, 0);
      send_frame(fa_x, fa_y, 1, 1, 0);
      push_list(fa_x, fa_y, ccw_ids, 0);
      send_frame(fa_x, fa_y, 0, 0, 0);

      rdy_mode = 2;
      for (int f = 0; f < 10; f++) begin
         bit m = 1'($urandom_range(0, 1));
         for (int i = 0; i < N; i++) begin
            rx[i] = (f < 3) ? 16 * $urandom_range(0, 15) : $urandom_range(0, 255);
            ry[i] = (f < 3) ? 16 * $urandom_range(0, 15) : $urandom_range(0, 255);
         end
         model_push(rx, ry, m);
         send_frame(rx, ry, m, 1'(f % 2), 3);
      end

      while (exp_q.size() > 0 && w < 5000) begin
         @(negedge clk);
         w++;
      end
      repeat (10) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      chk("final_idle", int'(out_valid), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
